dct_out_packer: RTL and testbench

Collects signed 2D-DCT coefficients from the DCT datapath one per handshake, packs eight of them into one 96-bit word, and writes the words sequentially into the 32768x96 output SRAM starting at address 0. It is the write side of the output image memory, and it fills the memory in the layout the bench dumps with `%b` (lane 0 in the MSBs). It reports progress and asserts `done` once the last address has been written.

---
 rtl/dct_out_packer.sv | 158 +++++++++++++++
 tb/tb_dct_out_packer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_out_packer.sv
// Packs signed DCT coefficients eight per 96-bit word and writes the words
// sequentially into the output SRAM, signalling done after the last address.
module dct_out_packer #(
    parameter int COEF_W = 12,
    parameter int LANES  = 8,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COEF_W-1:0]         in_data,
    input  logic                      flush,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [COEF_W*LANES-1:0]   mem_din,
    output logic [ADDR_W:0]           word_count,
    output logic                      done
);

    localparam int WORD_W = COEF_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_din_q, mem_din_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                done_q, done_d;
    logic                in_ready_q, in_ready_d;

    logic                accept;
    logic                last_lane;
    logic                word_done;
    logic                last_addr;
    logic [WORD_W-1:0]   pack_w;

    // A start pulse blocks acceptance in its own cycle, so the registered
    // ready is masked by it.
    assign in_ready = in_ready_q && !start;
    assign accept   = in_valid && in_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        addr_d       = addr_q;
        pack_d       = pack_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        word_count_d = word_count_q;
        done_d       = done_q;
        in_ready_d   = in_ready_q;

        last_lane = (lane_q == LANE_W'(LANES - 1));
        last_addr = (addr_q == ADDR_W'(DEPTH - 1));

        pack_w = pack_q;
        if (accept) begin
            pack_w[COEF_W*(LANES-1-int'(lane_q)) +: COEF_W] = in_data;
        end

        word_done = (state_q == PACK) &&
                    ((accept && last_lane) || (flush && (lane_q != '0 || accept)));

        // The count trails the write strobe by one cycle.
        if (mem_we_q) begin
            word_count_d = word_count_q + 1'b1;
        end

        if (start) begin
            state_d      = PACK;
            lane_d       = '0;
            addr_d       = '0;
            pack_d       = '0;
            word_count_d = '0;
            done_d       = 1'b0;
            in_ready_d   = 1'b1;
        end else begin
            case (state_q)
                PACK: begin
                    if (accept) begin
                        pack_d = pack_w;
                        lane_d = last_lane ? '0 : lane_q + 1'b1;
                    end
                    if (word_done) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = addr_q;
                        mem_din_d  = pack_w;
                        pack_d     = '0;
                        lane_d     = '0;
                        if (last_addr) begin
                            state_d    = DONE;
                            in_ready_d = 1'b0;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (mem_we_q) begin
                        done_d = 1'b1;
                    end
                end
                default: begin
                    in_ready_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            addr_q       <= '0;
            pack_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            addr_q       <= addr_d;
            pack_q       <= pack_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign word_count = word_count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dct_out_packer.sv
// Randomized bench for dct_out_packer: a queue-based model of accepted
// coefficients predicts every output cycle by cycle, plus directed checks.
module tb_dct_out_packer;

    localparam int COEF_W = 12;
    localparam int LANES  = 8;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;
    localparam int WORD_W = COEF_W * LANES;

    logic                clk;
    logic                reset;
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [COEF_W-1:0]   in_data;
    logic                flush;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_din;
    logic [ADDR_W:0]     word_count;
    logic                done;

    dct_out_packer #(
        .COEF_W(COEF_W),
        .LANES (LANES),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .word_count(word_count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Write monitor
    int                n_writes = 0;
    logic [ADDR_W-1:0] last_addr;
    logic [WORD_W-1:0] last_din;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_writes  = n_writes + 1;
            last_addr = mem_addr;
            last_din  = mem_din;
        end
    end

    // Reference model: 0 = idle, 1 = packing, 2 = finished
    int                m_state;
    logic [COEF_W-1:0] m_cur[$];
    int                m_addr;
    int                m_wc;
    bit                m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [WORD_W-1:0] m_wdin;

    function automatic logic [WORD_W-1:0] pack_cur();
        logic [WORD_W-1:0] w;
        w = '0;
        foreach (m_cur[i]) w[WORD_W-1-COEF_W*i -: COEF_W] = m_cur[i];
        return w;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cur.delete();
        m_addr  = 0;
        m_wc    = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdin  = '0;
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, advance model.
    task automatic step(input bit v, input logic [COEF_W-1:0] d, input bit f,
                        input bit s, input bit rst_lo);
        bit exp_ready;
        bit nxt_we;
        int wc_n;
        in_valid = v;
        in_data  = d;
        flush    = f;
        start    = s;
        reset    = rst_lo ? 1'b0 : 1'b1;
        @(negedge clk);
        exp_ready = (m_state == 1) && !s;
        n_vec++;
        if (in_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL step in_ready: got %b want %b (t=%0t)", in_ready, exp_ready, $time);
        end
        n_vec++;
        if (mem_we !== m_we) begin
            n_bad++;
            $display("FAIL step mem_we: got %b want %b (t=%0t)", mem_we, m_we, $time);
        end
        n_vec++;
        if (mem_addr !== m_waddr) begin
            n_bad++;
            $display("FAIL step mem_addr: got %0d want %0d (t=%0t)", mem_addr, m_waddr, $time);
        end
        n_vec++;
        if (mem_din !== m_wdin) begin
            n_bad++;
            $display("FAIL step mem_din: got %h want %h (t=%0t)", mem_din, m_wdin, $time);
        end
        n_vec++;
        if (word_count !== (ADDR_W+1)'(m_wc)) begin
            n_bad++;
            $display("FAIL step word_count: got %0d want %0d (t=%0t)", word_count, m_wc, $time);
        end
        n_vec++;
        if (done !== (m_wc == DEPTH)) begin
            n_bad++;
            $display("FAIL step done: got %b want %b (t=%0t)", done, (m_wc == DEPTH), $time);
        end

        if (rst_lo) begin
            model_reset();
        end else begin
            nxt_we = 1'b0;
            wc_n   = m_wc + int'(m_we);
            if (s) begin
                m_cur.delete();
                m_addr  = 0;
                wc_n    = 0;
                m_state = 1;
            end else if (m_state == 1) begin
                if (v && exp_ready) m_cur.push_back(d);
                if (m_cur.size() == LANES || (f && m_cur.size() > 0)) begin
                    nxt_we  = 1'b1;
                    m_waddr = ADDR_W'(m_addr);
                    m_wdin  = pack_cur();
                    m_cur.delete();
                    if (m_addr == DEPTH - 1) m_state = 2;
                    else m_addr = m_addr + 1;
                end
            end
            m_we = nxt_we;
            m_wc = wc_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        n_vec++;
        if ({in_ready, mem_we, mem_addr, mem_din, word_count, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%0d din=%h wc=%0d done=%b want all 0",
                     in_ready, mem_we, mem_addr, mem_din, word_count, done);
        end
        idle(2);
    endtask

    task automatic test_basic_word();
        int w0;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        w0 = n_writes;
        for (int i = 1; i <= LANES; i++) step(1'b1, COEF_W'(i), 1'b0, 1'b0, 1'b0);
        idle(1);
        n_vec++;
        if (n_writes - w0 != 1 || last_addr !== '0 ||
            last_din !== 96'h001002003004005006007008) begin
            n_bad++;
            $display("FAIL basic_word: got n=%0d addr=%0d din=%h want n=1 addr=0 din=001002003004005006007008",
                     n_writes - w0, last_addr, last_din);
        end
        n_vec++;
        if (word_count !== 8'd1) begin
            n_bad++;
            $display("FAIL basic_word_count: got %0d want 1", word_count);
        end
    endtask

    task automatic test_flush();
        int w0;
        w0 = n_writes;
        step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'h800, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'h7FF, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        n_vec++;
        if (n_writes - w0 != 1 || last_addr !== 7'd1 ||
            last_din !== 96'hFFF8007FF000000000000000) begin
            n_bad++;
            $display("FAIL flush_partial: got n=%0d addr=%0d din=%h want n=1 addr=1 din=FFF8007FF000000000000000",
                     n_writes - w0, last_addr, last_din);
        end
        w0 = n_writes;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(2);
        n_vec++;
        if (n_writes != w0) begin
            n_bad++;
            $display("FAIL flush_empty: got %0d writes want 0", n_writes - w0);
        end
        // flush together with an acceptance completes a one-lane word
        w0 = n_writes;
        step(1'b1, 12'h5A5, 1'b1, 1'b0, 1'b0);
        idle(1);
        n_vec++;
        if (n_writes - w0 != 1 || last_din !== {12'h5A5, 84'd0}) begin
            n_bad++;
            $display("FAIL flush_with_accept: got n=%0d din=%h want n=1 din=%h",
                     n_writes - w0, last_din, {12'h5A5, 84'd0});
        end
    endtask

    task automatic test_start_abort();
        int w0;
        logic [WORD_W-1:0] exp_w;
        logic [COEF_W-1:0] c;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        w0 = n_writes;
        for (int i = 0; i < 5; i++) step(1'b1, COEF_W'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'hABC, 1'b0, 1'b1, 1'b0);
        idle(1);
        n_vec++;
        if (n_writes != w0) begin
            n_bad++;
            $display("FAIL start_abort_nowrite: got %0d writes want 0", n_writes - w0);
        end
        exp_w = '0;
        for (int i = 0; i < LANES; i++) begin
            c = COEF_W'($urandom);
            exp_w[WORD_W-1-COEF_W*i -: COEF_W] = c;
            step(1'b1, c, 1'b0, 1'b0, 1'b0);
        end
        idle(1);
        n_vec++;
        if (n_writes - w0 != 1 || last_addr !== '0 || last_din !== exp_w) begin
            n_bad++;
            $display("FAIL start_abort_restart: got n=%0d addr=%0d din=%h want n=1 addr=0 din=%h",
                     n_writes - w0, last_addr, last_din, exp_w);
        end
    endtask

    task automatic test_reset_on_write();
        int w0;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        w0 = n_writes;
        for (int i = 0; i < LANES - 1; i++) step(1'b1, COEF_W'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'h123, 1'b0, 1'b0, 1'b1);
        idle(1);
        n_vec++;
        if (n_writes != w0 ||
            {in_ready, mem_we, mem_addr, mem_din, word_count, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_on_write: got n=%0d rdy=%b addr=%0d din=%h wc=%0d want n=0 all 0",
                     n_writes - w0, in_ready, mem_addr, mem_din, word_count);
        end
        for (int i = 0; i < 6; i++) step(1'b1, COEF_W'($urandom), 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (n_writes != w0) begin
            n_bad++;
            $display("FAIL idle_ignores_input: got %0d writes want 0", n_writes - w0);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < LANES; i++) step(1'b1, COEF_W'($urandom), 1'b0, 1'b0, 1'b0);
        idle(1);
        n_vec++;
        if (n_writes - w0 != 1 || last_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_then_start: got n=%0d addr=%0d want n=1 addr=0", n_writes - w0, last_addr);
        end
    endtask

    task automatic test_stream();
        int w0;
        int cyc;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        w0  = n_writes;
        cyc = 0;
        while (!(m_state == 2 && !m_we) && cyc < 20000) begin
            step($urandom_range(0, 3) != 0, COEF_W'($urandom), 1'b0, 1'b0, 1'b0);
            cyc++;
        end
        n_vec++;
        if (cyc >= 20000) begin
            n_bad++;
            $display("FAIL stream_timeout: got %0d writes after %0d cycles want %0d", n_writes - w0, cyc, DEPTH);
        end
        n_vec++;
        if (n_writes - w0 != DEPTH || done !== 1'b1 || word_count !== (ADDR_W+1)'(DEPTH) ||
            in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_end: got n=%0d done=%b wc=%0d rdy=%b want n=%0d done=1 wc=%0d rdy=0",
                     n_writes - w0, done, word_count, in_ready, DEPTH, DEPTH);
        end
        w0 = n_writes;
        for (int i = 0; i < 10; i++) step(1'b1, COEF_W'($urandom), 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (n_writes != w0 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_ignores_input: got %0d writes done=%b want 0 writes done=1", n_writes - w0, done);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (done !== 1'b0 || word_count !== '0) begin
            n_bad++;
            $display("FAIL restart_from_done: got done=%b wc=%0d want done=0 wc=0", done, word_count);
        end
        for (int i = 0; i < LANES; i++) step(1'b1, COEF_W'($urandom), 1'b0, 1'b0, 1'b0);
        idle(2);
        n_vec++;
        if (n_writes - w0 != 1 || last_addr !== '0) begin
            n_bad++;
            $display("FAIL restart_first_write: got n=%0d addr=%0d want n=1 addr=0", n_writes - w0, last_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_flush();
        test_start_abort();
        test_reset_on_write();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
